// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary to BCD converter with leading-zero mask
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     lz_mask
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * DIGITS + WIDTH;
  typedef enum logic {IDLE, CONV} state_t;
  state_t              state_q;
  logic [SW-1:0]       sr_q, sr_d;
  logic [CW-1:0]       cnt_q;
  logic [4*DIGITS-1:0] adj;
  logic [DIGITS-1:0]   lz_d;
  logic                zero_run;
  always_comb begin
    adj = sr_q[SW-1:WIDTH];
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = (sr_q[WIDTH+4*i+:4] >= 4'd5) ? sr_q[WIDTH+4*i+:4] + 4'd3 : sr_q[WIDTH+4*i+:4];
    sr_d = {adj, sr_q[WIDTH-1:0]} << 1;
    // walk down from the top digit; units digit is never blanked
    lz_d = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (sr_d[WIDTH+4*i+:4] == 4'd0);
      lz_d[i] = zero_run;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      lz_mask <= {{(DIGITS-1){1'b1}}, 1'b0};
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          sr_q    <= {{(4*DIGITS){1'b0}}, bin_in};
          cnt_q   <= CW'(WIDTH);
          state_q <= CONV;
          busy    <= 1'b1;
        end
      end else begin
        sr_q  <= sr_d;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
          bcd_out <= sr_d[SW-1:WIDTH];
          lz_mask <= lz_d;
        end
      end
    end
  end
endmodule
